multicycle_control: RTL

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/multicycle_control.sv | 245 ++++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_control.sv
// Multicycle instruction-sequencing controller for an RV32I-style datapath.
// Steps each instruction through FETCH, DECODE, EXEC, optional MEM and WB,
// drives the datapath control strobes for the current step, watches memory
// handshakes with an optional timeout, and traps on illegal opcodes or stalls.
//
// Ports:
//   clk_w_i              clock, all state changes on the rising edge
//   rst_w_i_h            synchronous active-high reset
//   run_w_i_h            start/continue sequencing
//   opcode_w_i[6:0]      opcode of the fetched instruction (sampled in DECODE)
//   mem_ready_w_i_h      memory completes the current fetch/load/store
//   branch_taken_w_i_h   comparator result for the current B-type instruction
//   fetch_req/mem_rd/mem_wr, ir_write/pc_write/pc_sel, reg_write and
//   writeback selects, ALU operand selects, jal/cmp_branch flags
//   state_w_o[2:0]       current state encoding
//   trap_w_o_h           sticky trap, trap_cause_w_o[1:0] its cause
//   instret_w_o          retired-instruction count (wraps)
module multicycle_control #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk_w_i,
  input  logic             rst_w_i_h,
  input  logic             run_w_i_h,
  input  logic [6:0]       opcode_w_i,
  input  logic             mem_ready_w_i_h,
  input  logic             branch_taken_w_i_h,
  output logic             fetch_req_w_o_h,
  output logic             mem_rd_w_o_h,
  output logic             mem_wr_w_o_h,
  output logic             ir_write_w_o_h,
  output logic             pc_write_w_o_h,
  output logic             pc_sel_w_o,
  output logic             reg_write_w_o_h,
  output logic             mem_to_reg_w_o_h,
  output logic             imm_to_reg_w_o_h,
  output logic             pc_to_reg_w_o,
  output logic             alu_src_a_w_o,
  output logic             alu_src_b_w_o,
  output logic             jal_w_o_h,
  output logic             cmp_branch_w_o_h,
  output logic [2:0]       state_w_o,
  output logic             trap_w_o_h,
  output logic [1:0]       trap_cause_w_o,
  output logic [CNT_W-1:0] instret_w_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6,
    S_RSVD   = 3'd7
  } state_e;

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_FETCH   = 2'b10;
  localparam logic [1:0] CAUSE_MEM     = 2'b11;

  // Counter wide enough to hold MEM_TIMEOUT; at least one bit when disabled.
  localparam int unsigned    TW       = $clog2(MEM_TIMEOUT + 2);
  localparam logic [TW-1:0]  TMO_LAST = (MEM_TIMEOUT == 0) ? '0 : TW'(MEM_TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [6:0]       op_q, op_d;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic [1:0]       cause_q, cause_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic             retire;
  logic             tmo_hit;

  logic is_jal, is_lui, is_auipc, is_branch, is_store, is_jalr, is_load, is_op;

  function automatic logic op_legal(input logic [6:0] op);
    case (op)
      OP_JAL, OP_LUI, OP_AUIPC, OP_BRANCH, OP_STORE,
      OP_JALR, OP_LOAD, OP_IMM, OP_OP: op_legal = 1'b1;
      default:                          op_legal = 1'b0;
    endcase
  endfunction

  always_comb begin
    is_jal    = (op_q == OP_JAL);
    is_lui    = (op_q == OP_LUI);
    is_auipc  = (op_q == OP_AUIPC);
    is_branch = (op_q == OP_BRANCH);
    is_store  = (op_q == OP_STORE);
    is_jalr   = (op_q == OP_JALR);
    is_load   = (op_q == OP_LOAD);
    is_op     = (op_q == OP_OP);
  end

  // The limit is reached in the cycle whose wait would make the count hit
  // MEM_TIMEOUT; a ready in that same cycle is checked first and wins.
  assign tmo_hit = (MEM_TIMEOUT != 0) && (tmo_q == TMO_LAST);

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    tmo_d     = '0;
    cause_d   = cause_q;
    retire    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (run_w_i_h) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (mem_ready_w_i_h) begin
          state_d = S_DECODE;
        end else if (tmo_hit) begin
          state_d = S_TRAP;
          cause_d = CAUSE_FETCH;
        end else if (MEM_TIMEOUT != 0) begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      S_DECODE: begin
        op_d = opcode_w_i;
        if (op_legal(opcode_w_i)) begin
          state_d = S_EXEC;
        end else begin
          state_d = S_TRAP;
          cause_d = CAUSE_ILLEGAL;
        end
      end
      S_EXEC: begin
        if (is_load || is_store) state_d = S_MEM;
        else if (is_branch)      retire  = 1'b1;
        else                     state_d = S_WB;
      end
      S_MEM: begin
        if (mem_ready_w_i_h) begin
          if (is_load) state_d = S_WB;
          else         retire  = 1'b1;
        end else if (tmo_hit) begin
          state_d = S_TRAP;
          cause_d = CAUSE_MEM;
        end else if (MEM_TIMEOUT != 0) begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      S_WB: begin
        retire = 1'b1;
      end
      S_TRAP: begin
        state_d = S_TRAP;
      end
      default: begin
        state_d = S_TRAP;
      end
    endcase
    // Run is only consulted at instruction boundaries, so dropping it
    // mid-instruction lets the instruction finish.
    if (retire) state_d = run_w_i_h ? S_FETCH : S_IDLE;
    instret_d = retire ? instret_q + CNT_W'(1) : instret_q;
  end

  always_ff @(posedge clk_w_i) begin
    if (rst_w_i_h) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      tmo_q     <= '0;
      cause_q   <= '0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      tmo_q     <= tmo_d;
      cause_q   <= cause_d;
      instret_q <= instret_d;
    end
  end

  // Control strobes decode from the registered state; the handshake-qualified
  // strobes (ir_write, store completion, branch pc_sel) follow the inputs in
  // the same cycle.
  always_comb begin
    fetch_req_w_o_h  = 1'b0;
    mem_rd_w_o_h     = 1'b0;
    mem_wr_w_o_h     = 1'b0;
    ir_write_w_o_h   = 1'b0;
    pc_write_w_o_h   = 1'b0;
    pc_sel_w_o       = 1'b0;
    reg_write_w_o_h  = 1'b0;
    mem_to_reg_w_o_h = 1'b0;
    imm_to_reg_w_o_h = 1'b0;
    pc_to_reg_w_o    = 1'b0;
    alu_src_a_w_o    = 1'b0;
    alu_src_b_w_o    = 1'b0;
    jal_w_o_h        = 1'b0;
    cmp_branch_w_o_h = 1'b0;
    trap_w_o_h       = 1'b0;
    case (state_q)
      S_FETCH: begin
        fetch_req_w_o_h = 1'b1;
        ir_write_w_o_h  = mem_ready_w_i_h;
      end
      S_EXEC: begin
        alu_src_a_w_o    = is_jal || is_auipc || is_branch;
        alu_src_b_w_o    = !is_op;
        jal_w_o_h        = is_jal || is_jalr;
        cmp_branch_w_o_h = is_branch;
        if (is_branch) begin
          pc_write_w_o_h = 1'b1;
          pc_sel_w_o     = branch_taken_w_i_h;
        end
      end
      S_MEM: begin
        mem_rd_w_o_h   = is_load;
        mem_wr_w_o_h   = is_store;
        pc_write_w_o_h = is_store && mem_ready_w_i_h;
      end
      S_WB: begin
        reg_write_w_o_h  = 1'b1;
        mem_to_reg_w_o_h = is_load;
        imm_to_reg_w_o_h = is_lui;
        pc_to_reg_w_o    = is_jal || is_jalr;
        pc_write_w_o_h   = 1'b1;
        pc_sel_w_o       = is_jal || is_jalr;
      end
      S_TRAP: begin
        trap_w_o_h = 1'b1;
      end
      default: ;
    endcase
  end

  assign state_w_o      = state_q;
  assign trap_cause_w_o = cause_q;
  assign instret_w_o    = instret_q;

endmodule
